// File: rtl/ext_pkg.sv
// Shared opcode encodings for the immediate-extension unit.
// The EXT_ILLEGAL_OP_EN macro changes how EXT_OP_RSVD is treated in ext_core and ext_unit_fifo.
package ext_pkg;

    typedef logic [1:0] ext_op_t;

    localparam ext_op_t EXT_OP_ZERO = 2'b00;
    localparam ext_op_t EXT_OP_SIGN = 2'b01;
    localparam ext_op_t EXT_OP_HIGH = 2'b10;
    localparam ext_op_t EXT_OP_RSVD = 2'b11;

endpackage

// File: rtl/ext_core.sv
// Combinational widening of an IN_W-bit immediate to OUT_W bits (zero, sign or high-place).
// Macro EXT_ILLEGAL_OP_EN: reserved op yields zero-extension with err=1; otherwise it acts as SIGN.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_op,
    output logic [OUT_W-1:0] imm_ext,
    output logic             err
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zeroExt;
    logic [OUT_W-1:0] signExt;
    logic [OUT_W-1:0] highExt;

    assign zeroExt = {{PAD_W{1'b0}}, in_imm};
    assign signExt = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    assign highExt = {in_imm, {PAD_W{1'b0}}};

    always_comb begin
        imm_ext = zeroExt;
        err     = 1'b0;
        case (in_op)
            EXT_OP_ZERO: imm_ext = zeroExt;
            EXT_OP_SIGN: imm_ext = signExt;
            EXT_OP_HIGH: imm_ext = highExt;
            default: begin
`ifdef EXT_ILLEGAL_OP_EN
                imm_ext = zeroExt;
                err     = 1'b1;
`else
                imm_ext = signExt;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ext_unit_fifo.sv
// Immediate-extension unit feeding a DEPTH-entry valid/ready FIFO toward the ALU-operand mux.
// Macro EXT_ILLEGAL_OP_EN: stores a per-entry error flag for the reserved op; otherwise out_err is 0.
module ext_unit_fifo
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_imm,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_imm,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [OUT_W-1:0] coreImm;
    logic             coreErr;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm  (in_imm),
        .in_op   (in_op),
        .imm_ext (coreImm),
        .err     (coreErr)
    );

    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [OUT_W-1:0] lastImm_q;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic             doPush, doPop;

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // flush wins over both handshakes, so neither side sees a transfer that cycle
    assign doPush = in_valid & in_ready & ~flush;
    assign doPop  = out_valid & out_ready & ~flush;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PW'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            lastImm_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (out_valid) lastImm_q <= mem_q[rdPtr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= coreImm;
    end

    // When empty, the output holds whatever head was last presented
    assign out_imm = out_valid ? mem_q[rdPtr_q] : lastImm_q;

`ifdef EXT_ILLEGAL_OP_EN
    logic errMem_q [DEPTH];
    logic lastErr_q;

    always_ff @(posedge clk) begin
        if (doPush) errMem_q[wrPtr_q] <= coreErr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastErr_q <= 1'b0;
        end else if (out_valid) begin
            lastErr_q <= errMem_q[rdPtr_q];
        end
    end

    assign out_err = out_valid ? errMem_q[rdPtr_q] : lastErr_q;
`else
    // ext_core drives err low in this build
    assign out_err = coreErr;
`endif

endmodule
